// File: rtl/sc_fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// sc_fir_seq_ctrl
//
// Frame sequencer for the stochastic-computing FIR datapath. Each frame it
// takes STRIDE samples (1/2/4) from the source into the tap delay line. It
// then clears the ones-counter, runs one STREAM_LEN-cycle bitstream evaluation
// while stepping the SNG index, and hands the final count out as the result.
// Loading and evaluation never overlap.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   enable                  allow a new frame to start (sampled in IDLE and at
//                           the output handshake only)
//   stride_sel[1:0]         00=1, 01=2, 10=4, 11=1; latched in IDLE only
//   in_valid/in_ready       input sample handshake, in_data[N:0]
//   shift_en, shift_data    tap delay line shift strobe and sample
//   sng_idx[N-1:0]          stream cycle index to the SNGs (0 outside RUN)
//   acc_clr, acc_en         ones-counter clear / count enable
//   result_count[N:0]       ones-counter value, 0..STREAM_LEN
//   out_valid/out_ready     result handshake, out_data[N:0], out_primed
//   busy                    sequencer is not idle
// -----------------------------------------------------------------------------
module sc_fir_seq_ctrl #(
    parameter int N          = 12,
    parameter int STREAM_LEN = 4096,
    parameter int TAPS       = 39
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [1:0]   stride_sel,
    input  logic         in_valid,
    input  logic [N:0]   in_data,
    output logic         in_ready,
    output logic         shift_en,
    output logic [N:0]   shift_data,
    output logic [N-1:0] sng_idx,
    output logic         acc_clr,
    output logic         acc_en,
    input  logic [N:0]   result_count,
    output logic         out_valid,
    output logic [N:0]   out_data,
    output logic         out_primed,
    input  logic         out_ready,
    output logic         busy
);

    // The fill counter only needs to reach the largest primed threshold.
    localparam int FILL_MAX = TAPS * 4;
    localparam int FW       = $clog2(FILL_MAX + 1);
    localparam logic [N-1:0]  LAST_IDX = N'(STREAM_LEN - 1);
    localparam logic [FW-1:0] FILL_TOP = FW'(FILL_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_RUN, S_SETTLE, S_CAPTURE, S_HOLD
    } state_t;

    state_t        state, next_state;
    logic [2:0]    stride;       // latched stride: 1, 2 or 4
    logic [2:0]    sel_stride;   // decoded stride_sel
    logic [2:0]    load_cnt;
    logic [N-1:0]  run_cnt;
    logic [FW-1:0] fill;
    logic [FW-1:0] primed_thr;
    logic          handshake;
    logic          load_done;
    logic          run_done;

    always_comb begin
        case (stride_sel)
            2'b01:   sel_stride = 3'd2;
            2'b10:   sel_stride = 3'd4;
            default: sel_stride = 3'd1;   // 11 is reserved and behaves as 1
        endcase
    end

    always_comb begin
        case (stride)
            3'd2:    primed_thr = FW'(TAPS * 2);
            3'd4:    primed_thr = FILL_TOP;
            default: primed_thr = FW'(TAPS);
        endcase
    end

    assign handshake = in_valid && (state == S_LOAD);
    assign load_done = handshake && ((load_cnt + 3'd1) == stride);
    assign run_done  = (state == S_RUN) && (run_cnt == LAST_IDX);

    // Outputs decoded straight from the state; shift_data is gated so that it
    // reads 0 whenever the sequencer is not loading.
    assign in_ready   = (state == S_LOAD);
    assign shift_en   = handshake;
    assign shift_data = (state == S_LOAD) ? in_data : '0;
    assign sng_idx    = (state == S_RUN) ? run_cnt : '0;
    assign acc_clr    = (state == S_CLEAR);
    assign acc_en     = (state == S_RUN);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of block ordering.
            state <= next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so every path assigns next_state and no latch
        // is inferred.
        next_state = state;
        case (state)
            S_IDLE:    if (enable) next_state = S_LOAD;
            S_LOAD:    if (load_done) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_RUN;
            S_RUN:     if (run_done) next_state = S_SETTLE;
            S_SETTLE:  next_state = S_CAPTURE;
            S_CAPTURE: next_state = S_HOLD;
            // out_valid is always set in HOLD, so out_ready alone completes
            // the handshake.
            S_HOLD:    if (out_ready) next_state = enable ? S_LOAD : S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stride     <= 3'd1;
            load_cnt   <= '0;
            run_cnt    <= '0;
            fill       <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_primed <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        stride <= sel_stride;
                        // Samples loaded at another stride do not count
                        // towards priming the new one.
                        if (sel_stride != stride) fill <= '0;
                    end
                end
                S_LOAD: begin
                    if (handshake) begin
                        if (fill != FILL_TOP) fill <= fill + FW'(1);
                        load_cnt <= load_done ? 3'd0 : load_cnt + 3'd1;
                    end
                end
                S_RUN: begin
                    run_cnt <= run_done ? '0 : run_cnt + N'(1);
                end
                S_CAPTURE: begin
                    out_data   <= result_count;
                    out_primed <= (fill >= primed_thr);
                    out_valid  <= 1'b1;
                end
                S_HOLD: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sc_fir_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sc_fir_seq_ctrl
//
// Bench for sc_fir_seq_ctrl with STREAM_LEN=16. A small ones-counter model
// counts bits of a per-frame 16-bit pattern indexed by sng_idx while acc_en
// is high, so each frame's expected result is the pattern's popcount.
// -----------------------------------------------------------------------------
module tb_sc_fir_seq_ctrl;

    localparam int N    = 12;
    localparam int SL   = 16;
    localparam int TAPS = 39;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [1:0]   stride_sel;
    logic         in_valid;
    logic [N:0]   in_data;
    logic         in_ready;
    logic         shift_en;
    logic [N:0]   shift_data;
    logic [N-1:0] sng_idx;
    logic         acc_clr;
    logic         acc_en;
    logic [N:0]   result_count;
    logic         out_valid;
    logic [N:0]   out_data;
    logic         out_primed;
    logic         out_ready;
    logic         busy;

    sc_fir_seq_ctrl #(.N(N), .STREAM_LEN(SL), .TAPS(TAPS)) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .stride_sel(stride_sel), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .shift_en(shift_en), .shift_data(shift_data),
        .sng_idx(sng_idx), .acc_clr(acc_clr), .acc_en(acc_en),
        .result_count(result_count), .out_valid(out_valid),
        .out_data(out_data), .out_primed(out_primed),
        .out_ready(out_ready), .busy(busy)
    );

    always #5 clock = ~clock;

    // Ones-counter model.
    logic [15:0] cur_pat;
    logic        force_en;
    logic [N:0]  force_val;
    logic [N:0]  rc;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                         rc <= '0;
        else if (acc_clr)                     rc <= '0;
        else if (acc_en && cur_pat[sng_idx[3:0]]) rc <= rc + 1'b1;
    end
    assign result_count = force_en ? force_val : rc;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one frame. All driving and sampling happens 1 time unit after a
    // rising edge. from_idle: start from IDLE by latching sel; stay_en: keep
    // enable high (next frame follows directly), otherwise enable is dropped
    // mid-RUN. stall: cycles out_ready is held low in HOLD.
    task automatic do_frame(input string name, input logic [1:0] sel,
                            input bit from_idle, input bit stay_en,
                            input logic [15:0] pat, input logic [N:0] base,
                            input int gap, input logic [N:0] exp_cnt,
                            input logic exp_primed, input int stall);
        int ns, k, clr_n, en_n, idx_bad, ld_bad, st_bad;
        logic [N:0] held;
        ns = (sel == 2'b01) ? 2 : (sel == 2'b10) ? 4 : 1;
        cur_pat = pat;
        if (from_idle) begin
            stride_sel = sel;
            enable     = 1'b1;
            @(posedge clock); #1;
        end
        // Any stride_sel change outside IDLE must be ignored.
        stride_sel = ~sel;
        ld_bad = 0;
        for (int i = 0; i < ns; i++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                #1;
                if (!in_ready || acc_en || acc_clr || shift_en) ld_bad++;
                @(posedge clock); #1;
            end
            in_valid = 1'b1;
            in_data  = base + (N+1)'(i);
            #1;
            check({name, "/shift_en"}, 32'(shift_en), 32'd1);
            check({name, "/shift_data"}, 32'(shift_data), 32'(base + (N+1)'(i)));
            @(posedge clock); #1;
            in_valid = 1'b0;
        end
        // k counts edges since the last accepting handshake.
        k = 0; clr_n = 0; en_n = 0; idx_bad = 0;
        while (!out_valid && k < 200) begin
            if (acc_clr) clr_n++;
            if (acc_en) begin
                en_n++;
                if (int'(sng_idx) != k - 1) idx_bad++;
            end else if (sng_idx != '0) idx_bad++;
            if (in_ready || shift_en) ld_bad++;
            if (!stay_en && k == 5) enable = 1'b0;
            @(posedge clock); #1;
            k++;
        end
        check({name, "/latency"}, 32'(k), 32'(SL + 3));
        check({name, "/acc_clr_cycles"}, 32'(clr_n), 32'd1);
        check({name, "/acc_en_cycles"}, 32'(en_n), 32'(SL));
        check({name, "/sng_idx_seq_errs"}, 32'(idx_bad), 32'd0);
        check({name, "/load_phase_errs"}, 32'(ld_bad), 32'd0);
        check({name, "/out_data"}, 32'(out_data), 32'(exp_cnt));
        check({name, "/out_primed"}, 32'(out_primed), 32'(exp_primed));
        held = out_data;
        st_bad = 0;
        for (int s = 0; s < stall; s++) begin
            @(posedge clock); #1;
            if (!out_valid || out_data !== held || in_ready ||
                out_primed !== exp_primed) st_bad++;
        end
        if (stall > 0) check({name, "/hold_stable_errs"}, 32'(st_bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        check({name, "/out_valid_cleared"}, 32'(out_valid), 32'd0);
        check({name, "/busy_after"}, 32'(busy), 32'(stay_en));
        check({name, "/in_ready_after"}, 32'(in_ready), 32'(stay_en));
    endtask

    typedef struct {
        string      name;
        logic [1:0] sel;
        logic [15:0] pat;
        logic [N:0] base;
        int         gap;
        logic [N:0] exp_cnt;
    } vec_t;

    vec_t tbl[5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        tbl[0] = '{"f1_s1_a5",    2'b00, 16'h0000, 13'h00A5, 0, 13'd0};
        tbl[1] = '{"f2_s1_ones",  2'b00, 16'hFFFF, 13'h0100, 0, 13'd16};
        tbl[2] = '{"f3_s2",       2'b01, 16'hAAAA, 13'h0200, 1, 13'd8};
        tbl[3] = '{"f4_s4_gaps",  2'b10, 16'h00F1, 13'h0300, 3, 13'd5};
        tbl[4] = '{"f5_sel11",    2'b11, 16'h8001, 13'h1FF0, 0, 13'd2};

        // Reset with active-looking inputs: every output must read 0.
        reset_n = 1'b0; enable = 1'b1; stride_sel = 2'b00;
        in_valid = 1'b1; in_data = 13'h00A5; out_ready = 1'b0;
        force_en = 1'b0; force_val = '0; cur_pat = '0;
        #1;
        check("reset/ctl", 32'({out_valid, out_primed, acc_en, acc_clr, busy,
                                in_ready, shift_en}), 32'd0);
        check("reset/data", 32'({out_data, shift_data}), 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reset/idx_held", 32'({sng_idx, busy, out_valid}), 32'd0);
        in_valid = 1'b0; enable = 1'b0;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("reset/idle_after", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++)
            do_frame(tbl[i].name, tbl[i].sel, 1'b1, 1'b0, tbl[i].pat,
                     tbl[i].base, tbl[i].gap, tbl[i].exp_cnt, 1'b0, 0);

        // Full-scale result held for 50 cycles without truncation.
        force_en = 1'b1; force_val = 13'h1000;
        do_frame("hold_full", 2'b00, 1'b1, 1'b0, 16'h0000, 13'h0055, 0,
                 13'h1000, 1'b0, 50);
        force_en = 1'b0;

        // Asynchronous reset mid-RUN.
        cur_pat = 16'hFFFF; stride_sel = 2'b00; enable = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b1; in_data = 13'h0011;
        @(posedge clock); #1;
        in_valid = 1'b0;
        w = 0;
        while (sng_idx != 12'd7 && w < 30) begin
            @(posedge clock); #1;
            w++;
        end
        check("rst_run/reached_idx7", 32'(sng_idx), 32'd7);
        reset_n = 1'b0;
        #1;
        check("rst_run/ctl_zero", 32'({out_valid, out_primed, acc_en, acc_clr,
                                       busy, in_ready, shift_en}), 32'd0);
        check("rst_run/data_zero", 32'({sng_idx, out_data}), 32'd0);
        #2;
        reset_n = 1'b1;
        #1;
        check("rst_run/idle_release", 32'(busy), 32'd0);
        enable = 1'b0;
        @(posedge clock); #1;
        check("rst_run/no_stale", 32'({busy, out_valid}), 32'd0);

        // Stride 1, 40 back-to-back frames: primed from frame 39.
        for (int f = 1; f <= 40; f++)
            do_frame($sformatf("s1_f%0d", f), 2'b00, f == 1, f != 40,
                     16'h1234, 13'(f * 16), 0, 13'd5, f >= 39, 0);

        // Switch to stride 2: fill restarts, primed once 78 samples loaded.
        for (int f = 1; f <= 39; f++)
            do_frame($sformatf("s2_f%0d", f), 2'b01, f == 1, f != 39,
                     16'h1234, 13'(f * 8), (f == 1) ? 2 : 0, 13'd5, f >= 39, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sc_fir_seq_ctrl.md
Name: sc_fir_seq_ctrl

Overview:
Frame sequencer for the stochastic-computing FIR datapath. It accepts binary input samples over a valid/ready handshake and shifts STRIDE of them into the tap delay line per output (decimation 1/2/4). It then runs one bitstream evaluation of STREAM_LEN cycles, driving the SNG index and accumulator controls, and returns the accumulated ones-count as the output sample with a valid/ready handshake. It sits between the sample source, the tap delay line, the SNG/multiplier array and the output counter.

Parameters:
N, 12, sample magnitude width; samples and results are N+1 bits.
STREAM_LEN, 4096, bitstream length per evaluation; must be 2^N for full precision and a power of two >= 4.
TAPS, 39, filter taps; used only for the primed flag.

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous, active-low reset
enable  in  1  allow new frames to start
stride_sel  in  2  00=1, 01=2, 10=4, 11=reserved (treated as 1)
in_valid  in  1  input sample valid
in_data  in  N+1  input sample
in_ready  out  1  sample accepted when in_valid&in_ready
shift_en  out  1  tap delay line shift strobe
shift_data  out  N+1  sample to shift in
sng_idx  out  N  stream cycle index to the SNGs
acc_clr  out  1  clear the ones-counter
acc_en  out  1  ones-counter count enable
result_count  in  N+1  ones-counter value, 0..STREAM_LEN
out_valid  out  1  result valid
out_data  out  N+1  captured result_count
out_primed  out  1  qualifies out_data: delay line fully filled
out_ready  in  1  result consumer ready
busy  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs 0, including out_data and out_primed. Load counter, stream counter and fill counter are 0. Reset asserted mid-frame aborts the frame immediately; no partial result is emitted.
- IDLE: if enable=1, latch stride (1/2/4) from stride_sel, go to LOAD next cycle. If the latched stride differs from the previous frame's stride, clear the fill counter.
- LOAD: in_ready=1. shift_en = in_valid & in_ready (combinational). shift_data = in_data (combinational pass-through). Each handshake increments the load count and the fill counter; the fill counter saturates at TAPS*4. When the handshake brings the load count to the stride, go to CLEAR. in_valid=0 stalls indefinitely. stride_sel changes outside IDLE are ignored.
- CLEAR: 1 cycle, acc_clr=1, in_ready=0. Go to RUN.
- RUN: exactly STREAM_LEN cycles. acc_en=1. sng_idx counts 0..STREAM_LEN-1, one per cycle. After the cycle with sng_idx=STREAM_LEN-1, go to SETTLE.
- sng_idx holds 0 outside RUN. acc_en=0 and acc_clr=0 outside their states.
- SETTLE: 1 cycle for the counter to absorb the last increment. Go to CAPTURE.
- CAPTURE: out_data <= result_count; out_primed <= (fill >= TAPS*stride); out_valid <= 1. Go to HOLD.
- HOLD: out_valid=1; out_data and out_primed stable.
  - On out_valid & out_ready: out_valid clears next cycle.
  - The next state is LOAD if enable=1, reusing the same stride without re-latching; otherwise IDLE.
- Latency: from the last accepting handshake to the out_valid rise is STREAM_LEN+3 cycles (CLEAR, RUN, SETTLE, CAPTURE).
- enable is sampled only in IDLE and at the HOLD handshake. Deasserting enable never truncates a frame in progress.
- in_ready=0 in every state except LOAD. There is no overlap between loading and evaluation.
- result_count equal to STREAM_LEN (all ones) is captured without truncation, since out_data is N+1 bits.

Test Plan:
- Reset with STREAM_LEN=16, stride_sel=00, enable=1, in_data=0x0A5 sent once → one shift_en pulse carrying shift_data=0x0A5; acc_clr for 1 cycle; acc_en for 16 cycles with sng_idx 0..15; out_valid rises 19 cycles after the handshake; out_data equals the model's result_count.
- stride_sel=10, four samples sent with in_valid gaps of 3 cycles → exactly 4 shift_en pulses; in_ready=0 from CLEAR until the handshake; no RUN before the 4th sample.
- TAPS=39, stride 1, 40 consecutive frames → out_primed=0 on frames 1..38 and out_primed=1 from frame 39 on. Switching to stride 2 in IDLE → fill counter clears; out_primed=0 until 78 samples have been loaded.
- out_ready held 0 for 50 cycles in HOLD → out_valid and out_data stable and in_ready=0. With result_count=STREAM_LEN, out_data=0x1000 for N=12.
- reset_n pulsed low at sng_idx=7 during RUN → all outputs 0 asynchronously; after release the state is IDLE; the next frame runs normally with no stale out_valid.
- enable dropped during RUN → frame completes and result is delivered; after the handshake the state is IDLE, busy=0, in_ready=0.
